// File: rtl/sampled_value_tracker.sv
// Tracks the previous enabled-tick sample of a signal and exposes stable/changed/rose/fell
// flags for the current sample, plus a saturating stable-run length and change count.
module sampled_value_tracker #(
   parameter int WIDTH     = 32,
   parameter int RUN_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [WIDTH-1:0]     value,
   output logic [WIDTH-1:0]     past_value,
   output logic                 stable,
   output logic                 changed,
   output logic                 rose,
   output logic                 fell,
   output logic [RUN_WIDTH-1:0] run_length,
   output logic [RUN_WIDTH-1:0] change_count
);

   logic [WIDTH-1:0]     past_q;
   logic                 valid_q;
   logic [RUN_WIDTH-1:0] run_q;
   logic [RUN_WIDTH-1:0] cnt_q;

   // Without history the live value is its own past, so the first tick reads as stable.
   always_comb begin
      past_value = valid_q ? past_q : value;
      stable     = (value == past_value);
      changed    = !stable;
      rose       = valid_q && !past_q[0] &&  value[0];
      fell       = valid_q &&  past_q[0] && !value[0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         past_q  <= '0;
         valid_q <= 1'b0;
         run_q   <= '0;
         cnt_q   <= '0;
      end else if (enable) begin
         past_q  <= value;
         valid_q <= 1'b1;
         if (changed) begin
            run_q <= '0;
            if (!(&cnt_q)) cnt_q <= cnt_q + RUN_WIDTH'(1);
         end else if (!(&run_q)) begin
            run_q <= run_q + RUN_WIDTH'(1);
         end
      end
   end

   assign run_length   = run_q;
   assign change_count = cnt_q;

endmodule

// File: tb/tb_sampled_value_tracker.sv
// Drives three tracker instances (32/16, 32/4 and 1/16) from shared stimulus and compares
// every output against a behavioural model each tick.
module tb_sampled_value_tracker;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [31:0] value = '0;

   logic [31:0] past_a, past_s;
   logic [0:0]  past_1;
   logic        stable_a, changed_a, rose_a, fell_a;
   logic        stable_s, changed_s, rose_s, fell_s;
   logic        stable_1, changed_1, rose_1, fell_1;
   logic [15:0] run_a, cnt_a, run_1, cnt_1;
   logic [3:0]  run_s, cnt_s;

   always #5 clk = ~clk;

   sampled_value_tracker #(.WIDTH(32), .RUN_WIDTH(16)) dut_a (
      .clk(clk), .reset(reset), .enable(enable), .value(value),
      .past_value(past_a), .stable(stable_a), .changed(changed_a), .rose(rose_a),
      .fell(fell_a), .run_length(run_a), .change_count(cnt_a));

   sampled_value_tracker #(.WIDTH(32), .RUN_WIDTH(4)) dut_s (
      .clk(clk), .reset(reset), .enable(enable), .value(value),
      .past_value(past_s), .stable(stable_s), .changed(changed_s), .rose(rose_s),
      .fell(fell_s), .run_length(run_s), .change_count(cnt_s));

   sampled_value_tracker #(.WIDTH(1), .RUN_WIDTH(16)) dut_1 (
      .clk(clk), .reset(reset), .enable(enable), .value(value[0:0]),
      .past_value(past_1), .stable(stable_1), .changed(changed_1), .rose(rose_1),
      .fell(fell_1), .run_length(run_1), .change_count(cnt_1));

   logic [31:0] o_past [3];
   logic [31:0] o_run  [3];
   logic [31:0] o_cnt  [3];
   logic [3:0]  o_flag [3];   // {stable, changed, rose, fell}

   assign o_past[0] = past_a;
   assign o_past[1] = past_s;
   assign o_past[2] = {31'b0, past_1};
   assign o_run[0]  = {16'b0, run_a};
   assign o_run[1]  = {28'b0, run_s};
   assign o_run[2]  = {16'b0, run_1};
   assign o_cnt[0]  = {16'b0, cnt_a};
   assign o_cnt[1]  = {28'b0, cnt_s};
   assign o_cnt[2]  = {16'b0, cnt_1};
   assign o_flag[0] = {stable_a, changed_a, rose_a, fell_a};
   assign o_flag[1] = {stable_s, changed_s, rose_s, fell_s};
   assign o_flag[2] = {stable_1, changed_1, rose_1, fell_1};

   // Reference model: history of the last enabled sample and plain integer counters.
   logic [31:0] m_past  [3];
   bit          m_valid [3];
   int          m_run   [3];
   int          m_cnt   [3];
   int          sat_max [3] = '{65535, 15, 65535};
   logic [31:0] w_mask  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1};

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic check_all(input string phase);
      for (int i = 0; i < 3; i++) begin
         logic [31:0] v, p;
         bit st, ro, fe;
         v  = value & w_mask[i];
         p  = m_valid[i] ? m_past[i] : v;
         st = (v == p);
         ro = m_valid[i] && (p % 2 == 0) && (v % 2 == 1);
         fe = m_valid[i] && (p % 2 == 1) && (v % 2 == 0);
         check($sformatf("%s/u%0d/past", phase, i), o_past[i], p);
         check($sformatf("%s/u%0d/flags", phase, i), {28'b0, o_flag[i]},
               {28'b0, st, !st, ro, fe});
         check($sformatf("%s/u%0d/run", phase, i), o_run[i], m_run[i]);
         check($sformatf("%s/u%0d/cnt", phase, i), o_cnt[i], m_cnt[i]);
      end
   endtask

   task automatic model_update(input bit rst, input bit en, input logic [31:0] val);
      for (int i = 0; i < 3; i++) begin
         logic [31:0] v;
         v = val & w_mask[i];
         if (rst) begin
            m_past[i] = '0; m_valid[i] = 0; m_run[i] = 0; m_cnt[i] = 0;
         end else if (en) begin
            if (m_valid[i] && v != m_past[i]) begin
               m_run[i] = 0;
               m_cnt[i] = (m_cnt[i] < sat_max[i]) ? m_cnt[i] + 1 : sat_max[i];
            end else begin
               m_run[i] = (m_run[i] < sat_max[i]) ? m_run[i] + 1 : sat_max[i];
            end
            m_past[i]  = v;
            m_valid[i] = 1;
         end
      end
   endtask

   task automatic step(input string phase, input bit rst, input bit en, input logic [31:0] val);
      @(negedge clk);
      reset = rst; enable = en; value = val;
      #2;
      check_all(phase);
      @(posedge clk);
      model_update(rst, en, val);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         m_past[i] = 'x; m_valid[i] = 0; m_run[i] = 0; m_cnt[i] = 0;
      end
      // Outputs are unknown before the first reset, so apply it without checking.
      @(negedge clk); reset = 1'b1; enable = 1'b1; value = '0;
      @(posedge clk); model_update(1, 1, 0);

      // Counter stimulus after reset.
      for (int k = 0; k < 4; k++) step("count", 0, 1, k);
      step("count_end", 0, 0, 3);
      check("count/change_count_is_3", {16'b0, cnt_a}, 32'd3);

      // Long hold: 4-bit run length saturates.
      for (int k = 0; k < 20; k++) step("hold", 0, 1, 32'h5A);
      step("hold_end", 0, 0, 32'h5A);
      check("hold/run_saturated_15", {28'b0, run_s}, 32'd15);

      // Movement while disabled is visible but not counted.
      step("dis", 0, 1, 7);
      step("dis", 0, 0, 8);
      step("dis", 0, 0, 9);
      step("dis", 0, 0, 9);
      check("dis/past_held_7", past_a, 32'd7);
      step("dis", 0, 1, 9);
      step("dis", 0, 0, 9);

      // Reset mid-run after several changes.
      for (int k = 0; k < 5; k++) step("rst", 0, 1, 100 + k * 3);
      step("rst", 1, 1, 200);
      step("rst", 0, 1, 32'hDEAD_BEEF);
      step("rst", 0, 0, 32'hDEAD_BEEF);

      // Wrap-around of the full-width value.
      step("wrap", 0, 1, 32'hFFFF_FFFF);
      step("wrap", 0, 0, 32'h0000_0000);
      check("wrap/fell", {31'b0, fell_a}, 32'd1);
      step("wrap", 0, 1, 32'h0000_0000);

      // LSB toggling from a fresh reset; 1-bit instance counts 7 changes.
      step("tog", 1, 0, 0);
      for (int k = 0; k < 8; k++) step("tog", 0, 1, k % 2);
      step("tog_end", 0, 0, 0);
      check("tog/w1_change_count_7", {16'b0, cnt_1}, 32'd7);

      // Randomized traffic with a narrow value pool so runs and LSB edges both occur.
      for (int k = 0; k < 400; k++) begin
         logic [31:0] v;
         bit r, e;
         v = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 3));
         e = ($urandom_range(0, 9) < 8);
         r = ($urandom_range(0, 49) == 0);
         step("rand", r, e, v);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
